serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A; captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B; captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the result is complete.
REQ-009 The block SHALL have port sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-010 The block SHALL have port carry, output, 1 bit: carry out of the MSB.

Function
REQ-011 The datapath SHALL be one bit-serial full-adder cell, built from two half-adder cells plus an OR gate, with a 1-bit carry flip-flop, a WIDTH-bit operand shift register per input, a WIDTH-bit result shift register and a bit counter.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN SHALL occur on an edge with start=1, latching a and b, clearing the carry flop and clearing the bit counter.
REQ-014 Each RUN edge SHALL consume the operand LSBs and the carry flop, shift the sum bit into the result MSB, shift both operands right by one, update the carry flop and increment the counter.
REQ-015 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1.
REQ-016 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-017 Latency: if start is accepted at edge E0, done SHALL be high for exactly the one cycle between E0+WIDTH and E0+WIDTH+1.
REQ-018 When done is high, sum and carry SHALL equal the low WIDTH bits and the bit WIDTH of a+b, using the operands captured at E0.
REQ-019 sum and carry SHALL hold their last completed values in IDLE until the next accepted start.
REQ-020 During RUN, sum and carry SHALL be don't-care to consumers; only values seen with done=1 or in IDLE are valid.
REQ-021 start while busy=1 SHALL be ignored, not queued, and changes to a/b SHALL NOT affect the operation in progress.
REQ-022 start held high continuously SHALL begin a new operation on the first edge in IDLE, giving back-to-back operations every WIDTH+2 cycles.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, carry=0, and clear the counter, carry flop and operand registers.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-025 The first start accepted after reset release SHALL behave as REQ-013.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN: when defined, the block SHALL add an input port sub (1 bit, latched with the operands).
REQ-027 With SERIAL_ADDER_SUB_EN defined and sub=1, the block SHALL invert the latched b and preset the carry flop to 1, so the result is a-b (mod 2^WIDTH) and carry=1 means no borrow.
REQ-028 With SERIAL_ADDER_SUB_EN defined and sub=0, or with the macro undefined, the block SHALL perform addition only, with no sub port.

Verification
REQ-029 WIDTH=8, a=0x00, b=0x00, start one cycle -> done pulses after 8 edges, sum=0x00, carry=0.
REQ-030 WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, carry=1; done high exactly one cycle; busy high for 9 cycles.
REQ-031 WIDTH=8, a=0xA5, b=0x5A, with start re-pulsed and a/b changed at cycle 3 of RUN -> sum=0xFF, carry=0; second start ignored.
REQ-032 rst_n pulsed low at cycle 4 of RUN on a=0x80, b=0x80 -> outputs zero immediately, no done pulse; a fresh start afterwards gives sum=0x00, carry=1.
REQ-033 With SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0; a=0x07, b=0x05, sub=1 -> sum=0x02, carry=1.
REQ-034 Random 1000-operation run at WIDTH=8 and WIDTH=16, start held high -> every done result matches the reference sum, with a period of WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, one result bit per clock, WIDTH+1 busy cycles.
// Define SERIAL_ADDER_SUB_EN to add a sub input selecting a-b instead of a+b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_in;
  logic             cy_init;

  // {carry, sum} of a half-adder cell
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  logic [1:0] h1;
  logic [1:0] h2;
  logic       fa_s;
  logic       fa_c;
  logic       last;

  assign h1   = ha(opa[0], opb[0]);
  assign h2   = ha(h1[0], cy);
  assign fa_s = h2[0];
  assign fa_c = h1[1] | h2[1];
  assign last = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; the +1 enters through the carry flop.
  assign b_in    = sub ? ~b : b;
  assign cy_init = sub;
`else
  assign b_in    = b;
  assign cy_init = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            opa   <= a;
            opb   <= b_in;
            cy    <= cy_init;
            cnt   <= '0;
            state <= RUN;
          end
        end
        (state == RUN): begin
          res <= {fa_s, res[WIDTH-1:1]};
          opa <= opa >> 1;
          opb <= opb >> 1;
          cy  <= fa_c;
          cnt <= cnt + 1'b1;
          if (last) state <= DONE;
        end
        (state == DONE): begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);
  assign sum   = res;
  assign carry = cy;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors plus
// randomized back-to-back runs at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8, bz8, d8, c8;
  logic [7:0]  a8, b8, sum8;
  logic        s16, bz16, d16, c16;
  logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_SUB_EN
  logic        sub8, sub16;
`endif

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .a(a8), .b(b8), .busy(bz8), .done(d8),
    .sum(sum8), .carry(c8)
  );

  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(s16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub16),
`endif
    .a(a16), .b(b16), .busy(bz16), .done(d16),
    .sum(sum16), .carry(c16)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One operation on the 8-bit instance; poke re-pulses start
  // with different operands in the middle of RUN.
  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     input logic sb, input bit poke);
    logic [8:0] e;
    int n;
    int bc;
    if (sb) e = {1'b0, x} + {1'b0, ~y} + 9'd1;
    else    e = {1'b0, x} + {1'b0, y};
    @(negedge clk);
    s8 = 1'b1;
    a8 = x;
    b8 = y;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = sb;
`endif
    tick();
    s8 = 1'b0;
    check("busy_after_start", bz8, 1);
    n = 0;
    bc = 1;
    while (!d8 && n < 20) begin
      s8 = poke && (n == 3);
      if (poke && n == 3) begin
        a8 = 8'h13;
        b8 = 8'h77;
      end
      tick();
      n++;
      if (bz8) bc++;
    end
    s8 = 1'b0;
    check("latency", n, 8);
    check("busy_cycles", bc, 9);
    check("sum", sum8, e[7:0]);
    check("carry", c8, e[8]);
    tick();
    check("done_width", d8, 0);
    check("idle_busy", bz8, 0);
    check("hold_sum", sum8, e[7:0]);
    check("hold_carry", c8, e[8]);
  endtask

  task automatic drive(input int w, input logic st,
                       input logic [31:0] x, input logic [31:0] y);
    if (w == 8) begin
      s8 = st;
      a8 = x[7:0];
      b8 = y[7:0];
    end else begin
      s16 = st;
      a16 = x[15:0];
      b16 = y[15:0];
    end
  endtask

  // Start held high: operation k is accepted at edge k*(w+2) and its
  // result must appear right after edge k*(w+2)+w.
  task automatic rnd(input int w, input int nops);
    logic [32:0] q[$];
    logic [32:0] e;
    logic [31:0] x, y, mask, gs;
    logic gd, gc;
    int t, acc, dn;
    mask = (32'd1 << w) - 32'd1;
    acc = 0;
    dn = 0;
    t = 0;
    @(negedge clk);
    x = $urandom & mask;
    y = $urandom & mask;
    drive(w, 1'b1, x, y);
    while (dn < nops) begin
      if (t % (w + 2) == 0 && acc < nops) begin
        q.push_back({1'b0, x} + {1'b0, y});
        acc++;
      end
      tick();
      gd = (w == 8) ? d8 : d16;
      gc = (w == 8) ? c8 : c16;
      gs = (w == 8) ? {24'd0, sum8} : {16'd0, sum16};
      if (t >= w && (t - w) % (w + 2) == 0) begin
        check("rnd_done", gd, 1);
        e = q.pop_front();
        check("rnd_sum", gs, e[31:0] & mask);
        check("rnd_carry", gc, e[w]);
        dn++;
      end else begin
        check("rnd_no_done", gd, 0);
      end
      x = $urandom & mask;
      y = $urandom & mask;
      drive(w, acc < nops, x, y);
      t++;
    end
    drive(w, 1'b0, x, y);
  endtask

  initial begin
    s8 = 0; a8 = 0; b8 = 0;
    s16 = 0; a16 = 0; b16 = 0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 0; sub16 = 0;
`endif
    #1;
    check("rst_busy", bz8, 0);
    check("rst_done", d8, 0);
    check("rst_sum", sum8, 0);
    check("rst_carry", c8, 0);
    check("rst_busy16", bz16, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op8(8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b0, 1'b1);

    // Reset in the middle of RUN aborts with no done pulse.
    @(negedge clk);
    s8 = 1'b1;
    a8 = 8'h80;
    b8 = 8'h80;
    tick();
    s8 = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", bz8, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bz8, 0);
    check("abort_done", d8, 0);
    check("abort_sum", sum8, 0);
    check("abort_carry", c8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort_no_done", d8, 0);
    end
    op8(8'h80, 8'h80, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h05, 8'h07, 1'b1, 1'b0);
    op8(8'h07, 8'h05, 1'b1, 1'b0);
    op8(8'h33, 8'h10, 1'b0, 1'b0);
`endif

    fork
      rnd(8, 1000);
      rnd(16, 1000);
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
